// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between instruction fetch
// and the MEM-stage load/store path.
//
// Handshake: a requester raises its req and holds req/addr/data stable
// until the same-cycle grant (o_*Gnt) is seen. A granted read returns
// o_*Valid/o_*RData exactly one cycle later. A granted store completes in
// its grant cycle. o_*Stall = req & ~gnt.
//
// Arbitration: data wins a conflict unless fetch has been denied
// STARVE_LIMIT consecutive cycles. Then fetch is forced through.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_FetchReq,
  input  logic [ADDR_W-1:0] i_FetchAddr,
  input  logic              i_DataReq,
  input  logic              i_DataWe,
  input  logic [3:0]        i_DataBe,
  input  logic [ADDR_W-1:0] i_DataAddr,
  input  logic [31:0]       i_DataWData,
  input  logic [31:0]       i_MemRData,
  output logic              o_MemEn,
  output logic [3:0]        o_MemWe,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [31:0]       o_MemWData,
  output logic              o_FetchGnt,
  output logic              o_FetchValid,
  output logic [31:0]       o_FetchRData,
  output logic              o_DataGnt,
  output logic              o_DataValid,
  output logic [31:0]       o_DataRData,
  output logic              o_FetchStall,
  output logic              o_DataStall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Which requester owns the RAM read data returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e      r_owner;
  owner_e      w_owner_next;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_next;
  logic [31:0] r_fetch_hold;
  logic [31:0] r_data_hold;

  logic        w_fetch_wins;
  logic        w_fetch_gnt;
  logic        w_data_gnt;
  logic        w_fetch_valid;
  logic        w_data_valid;

  // Grant decision: sole requester always wins; on conflict fetch wins only
  // once its starvation counter has hit the limit. Nothing is granted in reset.
  always_comb begin
    w_fetch_wins = i_FetchReq && (!i_DataReq || (r_starve_cnt == LIMIT));
    w_fetch_gnt  = !i_Rst && w_fetch_wins;
    w_data_gnt   = !i_Rst && i_DataReq && !w_fetch_wins;
  end

  // RAM port drive from the winner; write enables only for a granted store.
  always_comb begin
    o_MemEn    = w_fetch_gnt || w_data_gnt;
    o_MemWe    = (w_data_gnt && i_DataWe) ? i_DataBe : 4'b0000;
    o_MemAddr  = w_fetch_gnt ? i_FetchAddr : i_DataAddr;
    o_MemWData = i_DataWData;
  end

  // Grant and stall outputs.
  always_comb begin
    o_FetchGnt   = w_fetch_gnt;
    o_DataGnt    = w_data_gnt;
    o_FetchStall = i_FetchReq && !w_fetch_gnt;
    o_DataStall  = i_DataReq && !w_data_gnt;
  end

  // Next-state for the response owner and starvation counter.
  always_comb begin
    w_owner_next  = OWN_NONE;
    w_starve_next = 4'd0;
    if (w_fetch_gnt) begin
      w_owner_next = OWN_FETCH;
    end else if (w_data_gnt && !i_DataWe) begin
      w_owner_next = OWN_DATA;
    end
    // Counter saturates at the limit; at the limit fetch wins anyway.
    if (i_FetchReq && !w_fetch_gnt && !i_Rst) begin
      w_starve_next = (r_starve_cnt >= LIMIT) ? LIMIT : (r_starve_cnt + 4'd1);
    end
  end

  // State register for owner and starvation counter.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_owner      <= w_owner_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // Valid pulses are a decode of last cycle's owner.
  always_comb begin
    w_fetch_valid = (r_owner == OWN_FETCH);
    w_data_valid  = (r_owner == OWN_DATA);
  end

  // Per-requester read data hold registers capture RAM data on their valid.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_fetch_hold <= 32'd0;
      r_data_hold  <= 32'd0;
    end else begin
      if (w_fetch_valid) r_fetch_hold <= i_MemRData;
      if (w_data_valid)  r_data_hold  <= i_MemRData;
    end
  end

  // Read data passes RAM data through in the valid cycle, else the hold.
  always_comb begin
    o_FetchValid = w_fetch_valid;
    o_DataValid  = w_data_valid;
    o_FetchRData = w_fetch_valid ? i_MemRData : r_fetch_hold;
    o_DataRData  = w_data_valid  ? i_MemRData : r_data_hold;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width of the shared port.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, legal range 1..15: maximum consecutive cycles a fetch request may be denied before it is forced through.
REQ-003 SHALL have ports:
  i_Clk  in  1  single clock; all state updates on rising edge.
  i_Rst  in  1  synchronous reset, active-high.
  i_FetchReq  in  1  instruction-fetch read request.
  i_FetchAddr  in  ADDR_W  fetch address.
  i_DataReq  in  1  load/store request from the MEM stage.
  i_DataWe  in  1  1=store, 0=load.
  i_DataBe  in  4  store byte enables.
  i_DataAddr  in  ADDR_W  data address.
  i_DataWData  in  32  store data.
  i_MemRData  in  32  shared RAM read data, valid one cycle after the enabled read.
  o_MemEn  out  1  shared RAM enable.
  o_MemWe  out  4  shared RAM byte write enables.
  o_MemAddr  out  ADDR_W  shared RAM address.
  o_MemWData  out  32  shared RAM write data.
  o_FetchGnt  out  1  fetch accepted this cycle.
  o_FetchValid  out  1  fetch read data valid.
  o_FetchRData  out  32  fetch read data.
  o_DataGnt  out  1  data access accepted this cycle.
  o_DataValid  out  1  load read data valid.
  o_DataRData  out  32  load read data.
  o_FetchStall  out  1  equals i_FetchReq AND NOT o_FetchGnt; drives the front-end PC/decode hold.
  o_DataStall  out  1  equals i_DataReq AND NOT o_DataGnt; drives the pipeline freeze.

Function
REQ-004 SHALL grant combinationally in the request cycle; at most one of o_FetchGnt and o_DataGnt SHALL be 1 in any cycle, and neither SHALL be 1 without its request.
REQ-005 SHALL grant a sole requester unconditionally.
REQ-006 SHALL resolve a simultaneous request in favour of data while StarveCnt < STARVE_LIMIT, and in favour of fetch when StarveCnt == STARVE_LIMIT.
REQ-007 StarveCnt, 4 bits: SHALL increment when fetch requests and is denied; SHALL clear when fetch is granted or i_FetchReq=0; SHALL never exceed STARVE_LIMIT.
REQ-008 On a grant, SHALL drive o_MemEn=1 and o_MemAddr from the winner; o_MemWe = i_DataBe only for a granted store, else 4'b0000; o_MemWData = i_DataWData.
REQ-009 With no grant, SHALL drive o_MemEn=0 and o_MemWe=0; o_MemAddr and o_MemWData are don't-care.
REQ-010 SHALL register the response owner each cycle: FETCH for a granted fetch, DATA for a granted load, NONE for a store or no grant.
REQ-011 SHALL assert o_FetchValid for exactly the one cycle after a fetch grant, and o_DataValid for exactly the one cycle after a load grant.
REQ-012 In those cycles, SHALL drive o_FetchRData / o_DataRData = i_MemRData; otherwise SHALL hold the last valid value of each (registered hold, separate per requester).
REQ-013 Stores SHALL produce no valid pulse; a store grant completes in its grant cycle.
REQ-014 Back-to-back grants (any mix) SHALL be accepted every cycle with no bubble; the response of cycle N SHALL coincide with the grant of cycle N+1.
REQ-015 A requester SHALL hold request and address stable until granted; the block SHALL NOT latch addresses.

Reset
REQ-016 With i_Rst=1 at a clock edge: StarveCnt=0, response owner=NONE, both RData holds=0.
REQ-017 In the cycle after reset: o_FetchValid=0 and o_DataValid=0, including when a read was granted in the reset cycle.
REQ-018 While i_Rst=1: o_FetchGnt, o_DataGnt and o_MemEn SHALL be 0, and both stall outputs SHALL follow their requests.

Verification
REQ-019 Sole fetch, addr 0x100, RAM returns 0xDEADBEEF -> FetchGnt=1 and MemEn=1 in cycle 0; FetchValid=1 with RData=0xDEADBEEF in cycle 1; RData holds afterwards.
REQ-020 Both requesting continuously, STARVE_LIMIT=3 -> grant pattern D,D,D,F repeating; FetchStall=1 exactly in the D cycles; StarveCnt cycles 0,1,2,3,0.
REQ-021 Store addr 0x20, Be=4'b0011, with fetch pending -> MemWe=0011 and DataGnt=1; no DataValid next cycle; fetch granted next cycle.
REQ-022 Alternating load/fetch every cycle -> each Valid aligns one cycle after its own grant; no cross-routing of RData.
REQ-023 Load granted, i_Rst asserted on that edge -> DataValid=0 next cycle; DataRData=0; StarveCnt=0.
REQ-024 Fetch denied twice, then i_FetchReq drops for one cycle, then both request -> StarveCnt restarts at 0; data wins three more times before fetch.
